alu_power_sequencer: RTL and testbench
======================================

# alu_power_sequencer

Arbitration and power-sequencing controller for the shared power-gated ALU. It takes operation requests from NREQ requesters and grants them round-robin. It wakes the ALU power domain on demand, with a fixed wake-up delay and isolation release. After a programmable idle period it isolates the domain and powers it down. It sits between the requesting masters and the gated ALU datapath, which it contains.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 8, operand/result width
- WAKE_CYCLES, 4, cycles from power_enable rise to isolation release (≥1)
- IDLE_TIMEOUT, 3, consecutive request-free ACTIVE cycles before power-down (≥1)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request
- req_op  in  3*NREQ  packed op codes, slot i = [3i+2:3i]
- req_a, req_b  in  DW*NREQ  packed operands
- req_ready  out  NREQ  one-hot grant; transfer on valid&ready
- rsp_valid  out  1  result strobe
- rsp_id  out  $clog2(NREQ)  requester index of result
- rsp_result  out  DW  result
- power_enable  out  1  ALU domain supply enable
- iso_en  out  1  isolation clamp, active-high
- pwr_state  out  2  current FSM state encoding
- stat_wakes  out  16  wake-up count (see Configuration)
- stat_active  out  32  ACTIVE-cycle count (see Configuration)

## Operation
- The FSM has four states: OFF=0, WAKE=1, ACTIVE=2, ISOLATE=3.
- OFF: power_enable=0, iso_en=1. Any req_valid bit moves the FSM to WAKE.
- WAKE: power_enable=1, iso_en=1. The wake counter runs from 0. After WAKE_CYCLES cycles in WAKE the FSM moves to ACTIVE.
- ACTIVE: power_enable=1, iso_en=0. The idle counter clears on entry and on any cycle with a req_valid bit set; otherwise it increments.
  - When the idle counter reaches IDLE_TIMEOUT, the FSM moves to ISOLATE.
- ISOLATE: lasts one cycle, with power_enable=1 and iso_en=1.
  - If any req_valid bit is set in this cycle, the FSM returns to ACTIVE with the idle counter cleared.
  - Otherwise it moves to OFF.
- Grants:
  - req_ready is combinational. It is nonzero only in ACTIVE, and only for the round-robin winner among the asserted req_valid bits.
  - Search starts at last_grant+1 mod NREQ. The pointer updates only on a transfer.
- Datapath ops:
  - 001 = A+B, 010 = A−B, 011 = A&B, 100 = A|B, 101 = A^B. Add and subtract are mod 2^DW, with carry and borrow discarded.
  - 000 and 110/111 return 0. They still count as activity.
- Requesters hold valid, op and operands stable until ready. A requester may drop valid before ready; no penalty applies.
- Reset values:
  - FSM is in OFF, so power_enable=0 and iso_en=1.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0.
  - last_grant=NREQ−1, so requester 0 wins first.
  - Counters are 0.

## Timing
- Cold start: req_valid rises at cycle t with the FSM in OFF.
  - Cycles t+1 .. t+WAKE_CYCLES are WAKE.
  - The FSM is in ACTIVE at t+WAKE_CYCLES+1. The first transfer happens in that cycle.
- Response: registered. rsp_valid, rsp_id and rsp_result are valid exactly one cycle after a transfer, for one cycle. Throughput is one transfer per cycle in ACTIVE.
- Power-down: with no requests in ACTIVE, ISOLATE is entered IDLE_TIMEOUT cycles after the last active cycle. OFF follows one cycle later.
- A response for the last transfer always issues before OFF, because IDLE_TIMEOUT ≥ 1.
- Simultaneous requests: only one is granted per cycle. No requester waits more than NREQ−1 transfers.
- A request arriving in the same cycle the FSM enters OFF is seen in OFF and starts WAKE on the next edge.
- Reset asserted mid-operation forces all reset values immediately. Any pending response is dropped.

## Configuration
- ALU_PWR_STATS_EN
  - Defined: stat_wakes increments on each OFF→WAKE transition and saturates at 0xFFFF. stat_active increments on every ACTIVE cycle and saturates. Both clear on reset.
  - Undefined: the counters are not built, and stat_wakes and stat_active are tied to 0.

## Structure
- Package alu_pwr_pkg holds:
  - op-code localparams (OP_NOP..OP_XOR)
  - the pwr_state_t enum (OFF/WAKE/ACTIVE/ISOLATE)
  - the counter-width helper function
- Sub-module rr_arbiter (parameter N): inputs are req and the advance strobe; outputs are the one-hot grant and the registered last-grant pointer.
- The ALU case logic is inline in the top.

## Test plan
- Cold wake: NREQ=4, WAKE_CYCLES=4, req 0 with op 001, A=0x0F, B=0x01 at cycle 10.
  - WAKE in cycles 11–14, ready[0] at 15.
  - rsp at 16: id=0, result=0x10.
- Round-robin: requesters 0–3 all valid in ACTIVE. Grants go 0,1,2,3,0; rsp_ids follow one cycle later.
- Wrap and ops: op 010 with 0x00−0x01 gives 0xFF. op 101 with 0xAA^0xFF gives 0x55. op 111 gives 0x00.
- Idle power-down: IDLE_TIMEOUT=3, last transfer at cycle t.
  - ISOLATE at t+4 (iso_en=1, power_enable=1).
  - OFF at t+5 (power_enable=0).
- ISOLATE abort: a request arrives in the ISOLATE cycle. The FSM returns to ACTIVE next cycle with no power drop, and the transfer completes.
- Reset mid-burst: assert reset during back-to-back transfers.
  - Outputs return to reset values that cycle, and no rsp_valid appears.
  - With ALU_PWR_STATS_EN, the stats read 0.

Source files
------------

// File: rtl/alu_pwr_pkg.sv
// Shared definitions for the power-gated ALU sequencer: op codes,
// power FSM state encoding and a counter-width helper.
package alu_pwr_pkg;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;

   typedef enum logic [1:0] {
      OFF     = 2'd0,
      WAKE    = 2'd1,
      ACTIVE  = 2'd2,
      ISOLATE = 2'd3
   } pwr_state_t;

   // Bits needed to hold values 0..n (at least one bit).
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/alu_power_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from last_grant+1, pointer
// advances only when the granted request actually transfers.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic                 advance,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] last_grant
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] idx_w;
   logic          found;

   // Pick the first asserted request after the previous winner.
   always_comb begin
      grant   = '0;
      gnt_idx = last_grant;
      idx_w   = '0;
      found   = 1'b0;
      for (int i = 1; i <= N; i++) begin
         idx_w = IW'((int'(last_grant) + i) % N);
         if (!found && req[idx_w]) begin
            grant[idx_w] = 1'b1;
            gnt_idx      = idx_w;
            found        = 1'b1;
         end
      end
   end

   // Remember the last winner; reset value makes requester 0 win first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_grant <= IW'(N - 1);
      else if (advance)
         last_grant <= gnt_idx;
   end

endmodule

// File: rtl/alu_power_sequencer.sv
// Arbitration and power sequencing for the shared power-gated ALU.
// Optional build macro ALU_PWR_STATS_EN adds saturating wake/active counters;
// without it stat_wakes and stat_active are tied to zero.
module alu_power_sequencer
   import alu_pwr_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int DW           = 8,
   parameter int WAKE_CYCLES  = 4,
   parameter int IDLE_TIMEOUT = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [3*NREQ-1:0]       req_op,
   input  logic [DW*NREQ-1:0]      req_a,
   input  logic [DW*NREQ-1:0]      req_b,
   output logic [NREQ-1:0]         req_ready,
   output logic                    rsp_valid,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [DW-1:0]           rsp_result,
   output logic                    power_enable,
   output logic                    iso_en,
   output logic [1:0]              pwr_state,
   output logic [15:0]             stat_wakes,
   output logic [31:0]             stat_active
);

   localparam int IW  = $clog2(NREQ);
   localparam int WCW = cnt_w(WAKE_CYCLES);
   localparam int ICW = cnt_w(IDLE_TIMEOUT);

   pwr_state_t     state, state_nxt;
   logic [WCW-1:0] wake_cnt, wake_cnt_nxt;
   logic [ICW-1:0] idle_cnt, idle_cnt_nxt;
   logic           any_req;
   logic [NREQ-1:0] grant;
   logic [IW-1:0]   last_grant;
   logic            xfer_p0;
   logic [2:0]      sel_op_p0;
   logic [DW-1:0]   sel_a_p0, sel_b_p0, alu_res_p0;

   assign any_req   = |req_valid;
   assign pwr_state = state;

   // Next-state, wake/idle counter updates and power/isolation controls.
   always_comb begin
      state_nxt    = state;
      wake_cnt_nxt = wake_cnt;
      idle_cnt_nxt = idle_cnt;
      power_enable = 1'b0;
      iso_en       = 1'b1;
      case (state)
         OFF: begin
            if (any_req) begin
               state_nxt    = WAKE;
               wake_cnt_nxt = '0;
            end
         end
         WAKE: begin
            power_enable = 1'b1;
            if (wake_cnt == WCW'(WAKE_CYCLES - 1)) begin
               state_nxt    = ACTIVE;
               idle_cnt_nxt = '0;
            end else begin
               wake_cnt_nxt = wake_cnt + WCW'(1);
            end
         end
         ACTIVE: begin
            power_enable = 1'b1;
            iso_en       = 1'b0;
            if (any_req) begin
               idle_cnt_nxt = '0;
            end else begin
               idle_cnt_nxt = idle_cnt + ICW'(1);
               if (idle_cnt == ICW'(IDLE_TIMEOUT - 1))
                  state_nxt = ISOLATE;
            end
         end
         ISOLATE: begin
            power_enable = 1'b1;
            if (any_req) begin
               state_nxt    = ACTIVE;
               idle_cnt_nxt = '0;
            end else begin
               state_nxt = OFF;
            end
         end
         default: state_nxt = OFF;
      endcase
   end

   // Power FSM state and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= OFF;
         wake_cnt <= '0;
         idle_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wake_cnt <= wake_cnt_nxt;
         idle_cnt <= idle_cnt_nxt;
      end
   end

   rr_arbiter #(.N(NREQ)) u_arb (
      .clk        (clk),
      .reset      (reset),
      .req        (req_valid & {NREQ{state == ACTIVE}}),
      .advance    (xfer_p0),
      .grant      (grant),
      .last_grant (last_grant)
   );

   assign req_ready = grant;
   assign xfer_p0   = |(req_valid & grant);

   // Stage p0: one-hot operand select and ALU evaluation for the winner.
   always_comb begin
      sel_op_p0  = OP_NOP;
      sel_a_p0   = '0;
      sel_b_p0   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_op_p0 = req_op[3*i +: 3];
            sel_a_p0  = req_a[DW*i +: DW];
            sel_b_p0  = req_b[DW*i +: DW];
         end
      end
      case (sel_op_p0)
         OP_ADD:  alu_res_p0 = sel_a_p0 + sel_b_p0;
         OP_SUB:  alu_res_p0 = sel_a_p0 - sel_b_p0;
         OP_AND:  alu_res_p0 = sel_a_p0 & sel_b_p0;
         OP_OR:   alu_res_p0 = sel_a_p0 | sel_b_p0;
         OP_XOR:  alu_res_p0 = sel_a_p0 ^ sel_b_p0;
         default: alu_res_p0 = '0;
      endcase
   end

   // Stage p1: registered response, one cycle after the transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
      end else begin
         rsp_valid <= xfer_p0;
         if (xfer_p0)
            rsp_result <= alu_res_p0;
      end
   end

   // The arbiter pointer already holds the last winner, which is the id of
   // the response being presented; report zero when no response is present.
   assign rsp_id = rsp_valid ? last_grant : '0;

`ifdef ALU_PWR_STATS_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Saturating wake-up and active-cycle statistics.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_wakes  <= '0;
         stat_active <= '0;
      end else begin
         if (state == OFF && state_nxt == WAKE)
            stat_wakes <= sat_inc16(stat_wakes);
         if (state == ACTIVE)
            stat_active <= sat_inc32(stat_active);
      end
   end
`else
   assign stat_wakes  = '0;
   assign stat_active = '0;
`endif

endmodule

// File: tb/tb_alu_power_sequencer.sv
// Directed bench for alu_power_sequencer (NREQ=4, DW=8, WAKE_CYCLES=4,
// IDLE_TIMEOUT=3) with hand-computed expected values.
module tb_alu_power_sequencer;

   localparam int NREQ = 4;
   localparam int DW   = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [NREQ-1:0]  req_valid;
   logic [3*NREQ-1:0] req_op;
   logic [DW*NREQ-1:0] req_a, req_b;
   logic [NREQ-1:0]  req_ready;
   logic             rsp_valid;
   logic [1:0]       rsp_id;
   logic [DW-1:0]    rsp_result;
   logic             power_enable, iso_en;
   logic [1:0]       pwr_state;
   logic [15:0]      stat_wakes;
   logic [31:0]      stat_active;

   int n_tests = 0;
   int n_fail  = 0;

   alu_power_sequencer #(
      .NREQ(NREQ), .DW(DW), .WAKE_CYCLES(4), .IDLE_TIMEOUT(3)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .power_enable(power_enable), .iso_en(iso_en),
      .pwr_state(pwr_state), .stat_wakes(stat_wakes), .stat_active(stat_active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      req_valid[i]     = 1'b1;
      req_op[3*i +: 3] = op;
      req_a[8*i +: 8]  = a;
      req_b[8*i +: 8]  = b;
   endtask

   task automatic do_reset;
      reset     = 1'b1;
      req_valid = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_pwr(input string tag, input logic [1:0] st, input logic pe, input logic iso);
      chk({tag, "_state"}, pwr_state, st);
      chk({tag, "_pe"}, power_enable, pe);
      chk({tag, "_iso"}, iso_en, iso);
   endtask

   initial begin
      reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
      repeat (3) tick();

      // Reset state
      chk_pwr("rst", 2'd0, 1'b0, 1'b1);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_wakes", stat_wakes, 0);
      chk("rst_active", stat_active, 0);
      reset = 1'b0;
      tick();
      chk("off_stays", pwr_state, 0);

      // Cold wake: request 0x0F+0x01 arrives while OFF
      set_req(0, 3'b001, 8'h0F, 8'h01);
      #1;
      chk("cold_t_state", pwr_state, 0);
      chk("cold_t_ready", req_ready, 0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk_pwr($sformatf("wake%0d", k), 2'd1, 1'b1, 1'b1);
         chk($sformatf("wake%0d_ready", k), req_ready, 0);
      end
      tick();
      chk_pwr("active_entry", 2'd2, 1'b1, 1'b0);
      chk("first_ready", req_ready, 4'b0001);
      tick();
      chk("cold_rsp_valid", rsp_valid, 1);
      chk("cold_rsp_id", rsp_id, 0);
      chk("cold_rsp_result", rsp_result, 8'h10);
      req_valid = '0;
      #1;
      chk("idle1_ready", req_ready, 0);
      tick();
      chk("idle2_rsp_valid", rsp_valid, 0);
      chk("idle2_state", pwr_state, 2);
      tick();
      chk("idle3_state", pwr_state, 2);
      tick();
      chk_pwr("isolate", 2'd3, 1'b1, 1'b1);
`ifdef ALU_PWR_STATS_EN
      chk("stat_wakes1", stat_wakes, 1);
      chk("stat_active4", stat_active, 4);
`else
      chk("stat_wakes_tied", stat_wakes, 0);
      chk("stat_active_tied", stat_active, 0);
`endif
      tick();
      chk_pwr("off_again", 2'd0, 1'b0, 1'b1);

      // Round-robin with all four requesters and assorted ops
      do_reset();
      set_req(0, 3'b001, 8'h01, 8'h02);   // 0x03
      set_req(1, 3'b010, 8'h00, 8'h01);   // 0xFF wrap
      set_req(2, 3'b101, 8'hAA, 8'hFF);   // 0x55
      set_req(3, 3'b111, 8'h12, 8'h34);   // 0x00
      repeat (5) tick();
      chk("rr_c0_state", pwr_state, 2);
      chk("rr_c0_ready", req_ready, 4'b0001);
      tick();
      chk("rr_c1_ready", req_ready, 4'b0010);
      chk("rr_c1_rsp_id", rsp_id, 0);
      chk("rr_c1_result", rsp_result, 8'h03);
      set_req(0, 3'b011, 8'hF0, 8'h3C);   // 0x30
      tick();
      chk("rr_c2_ready", req_ready, 4'b0100);
      chk("rr_c2_rsp_id", rsp_id, 1);
      chk("rr_c2_result", rsp_result, 8'hFF);
      tick();
      chk("rr_c3_ready", req_ready, 4'b1000);
      chk("rr_c3_rsp_id", rsp_id, 2);
      chk("rr_c3_result", rsp_result, 8'h55);
      tick();
      chk("rr_c4_ready", req_ready, 4'b0001);
      chk("rr_c4_rsp_id", rsp_id, 3);
      chk("rr_c4_result", rsp_result, 8'h00);
      tick();
      chk("rr_c5_rsp_valid", rsp_valid, 1);
      chk("rr_c5_rsp_id", rsp_id, 0);
      chk("rr_c5_result", rsp_result, 8'h30);
      req_valid = '0;

      // ISOLATE abort: request shows up during the ISOLATE cycle
      tick();
      tick();
      tick();
      chk_pwr("abort_iso", 2'd3, 1'b1, 1'b1);
      set_req(2, 3'b100, 8'h0F, 8'hF0);   // 0xFF
      #1;
      chk("abort_iso_ready", req_ready, 0);
      tick();
      chk_pwr("abort_active", 2'd2, 1'b1, 1'b0);
      chk("abort_ready", req_ready, 4'b0100);
      tick();
      chk("abort_rsp_valid", rsp_valid, 1);
      chk("abort_rsp_id", rsp_id, 2);
      chk("abort_result", rsp_result, 8'hFF);

      // Reset in the middle of back-to-back transfers
      req_valid = '0;
      set_req(0, 3'b001, 8'h80, 8'h81);   // 0x01, carry dropped
      set_req(1, 3'b010, 8'h05, 8'h03);   // 0x02
      #1;
      chk("b2b_ready0", req_ready, 4'b0001);
      tick();
      chk("b2b_ready1", req_ready, 4'b0010);
      chk("b2b_rsp_id", rsp_id, 0);
      chk("b2b_result", rsp_result, 8'h01);
      #2;
      reset = 1'b1;
      #1;
      chk_pwr("mid_rst", 2'd0, 1'b0, 1'b1);
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_rsp_id", rsp_id, 0);
      chk("mid_rst_result", rsp_result, 0);
      chk("mid_rst_wakes", stat_wakes, 0);
      chk("mid_rst_active", stat_active, 0);
      req_valid = '0;
      tick();
      chk("mid_rst_no_rsp", rsp_valid, 0);
      reset = 1'b0;
      tick();
      chk("post_rst_no_rsp", rsp_valid, 0);
      chk("post_rst_state", pwr_state, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
